// File: rtl/bcd_display_scanner_pkg.sv
// Shared constants and FSM encoding for the multiplexed 7-segment scanner.
// Latency: n/a (declarations only); backpressure: n/a.
package bcd_display_scanner_pkg;

   localparam logic [0:6] SEG_BLANK = 7'b1111111;

   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } state_t;

endpackage

// File: rtl/bcd_display_scanner_decode.sv
// BCD nibble to active-low a..g segment pattern; codes A-F decode to blank.
// Latency: combinational; backpressure: none.
module bcd_display_scanner_decode
   import bcd_display_scanner_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [0:6] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (bcd)
         4'd0: seg = 7'b0000001;
         4'd1: seg = 7'b1001111;
         4'd2: seg = 7'b0010010;
         4'd3: seg = 7'b0000110;
         4'd4: seg = 7'b1001100;
         4'd5: seg = 7'b0100100;
         4'd6: seg = 7'b0100000;
         4'd7: seg = 7'b0001111;
         4'd8: seg = 7'b0000000;
         4'd9: seg = 7'b0001100;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/bcd_display_scanner.sv
// Scans a double-buffered BCD value across common-anode digits with dead-time and LZ blanking.
// Latency: seg/an registered, a load shows from the next frame; backpressure: none, last load before the wrap wins.
module bcd_display_scanner
   import bcd_display_scanner_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int BLANK_GAP   = 2,
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value_in,
   input  logic                    lz_blank_en,
   output logic [0:6]              seg,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [IW-1:0]           digit_idx,
   output logic                    pending,
   output logic                    frame_done
);

   localparam int              CW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0]   GAP_LAST  = CW'(BLANK_GAP - 1);
   localparam logic [CW-1:0]   SLOT_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0]   DIG_LAST  = IW'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] AN_OFF = '1;

   state_t                  state;
   logic [CW-1:0]           cnt;
   logic [4*NUM_DIGITS-1:0] shadow;
   logic [4*NUM_DIGITS-1:0] active;
   logic [3:0]              cur_nib;
   logic [0:6]              dec_seg;
   logic [0:6]              next_seg;
   logic [NUM_DIGITS-1:0]   lz_mask;
   logic                    zero_above;
   logic                    slot_end;
   logic                    wrap;

   assign slot_end = (state == SHOW) && (cnt == SLOT_LAST);
   assign wrap     = slot_end && (digit_idx == DIG_LAST);
   assign cur_nib  = active[4*int'(digit_idx) +: 4];

   bcd_display_scanner_decode u_decode (
      .bcd (cur_nib),
      .seg (dec_seg)
   );

   // A digit is a leading zero when it and every more significant digit are 0; digit 0 never is.
   always_comb begin
      lz_mask    = '0;
      zero_above = 1'b1;
      for (int k = NUM_DIGITS - 1; k > 0; k--) begin
         zero_above = zero_above && (active[4*k +: 4] == 4'd0);
         lz_mask[k] = zero_above;
      end
   end

   assign next_seg = (lz_blank_en && lz_mask[digit_idx]) ? SEG_BLANK : dec_seg;

   // One counter spans the whole slot: dead-time occupies the first BLANK_GAP counts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= BLANK;
         cnt        <= '0;
         digit_idx  <= '0;
         an         <= AN_OFF;
         seg        <= SEG_BLANK;
         frame_done <= 1'b0;
      end else begin
         frame_done <= wrap;
         cnt        <= slot_end ? '0 : cnt + 1'b1;
         case (state)
            BLANK: begin
               if (cnt == GAP_LAST) begin
                  state <= SHOW;
                  an    <= ~(NUM_DIGITS'(1) << digit_idx);
                  seg   <= next_seg;
               end
            end
            SHOW: begin
               if (slot_end) begin
                  state     <= BLANK;
                  an        <= AN_OFF;
                  seg       <= SEG_BLANK;
                  digit_idx <= wrap ? '0 : digit_idx + 1'b1;
               end
            end
            default: state <= BLANK;
         endcase
      end
   end

   // Active only changes on the wrap edge, so a frame never mixes old and new digits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow  <= '0;
         active  <= '0;
         pending <= 1'b0;
      end else begin
         if (load)
            shadow <= value_in;
         if (wrap) begin
            if (load)
               active <= value_in;
            else if (pending)
               active <= shadow;
            pending <= 1'b0;
         end else if (load) begin
            pending <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed and random checks of the scanner against a slot/frame arithmetic model.
// Latency: n/a; backpressure: n/a.
module tb_bcd_display_scanner;

   logic        clk = 1'b0;
   logic        rst;
   logic        load;
   logic [15:0] value_in;
   logic        lz_blank_en;
   logic [0:6]  seg;
   logic [3:0]  an;
   logic [1:0]  digit_idx;
   logic        pending;
   logic        frame_done;

   int total  = 0;
   int passes = 0;

   int          n;
   logic [15:0] m_act;
   logic [15:0] m_sh;
   bit          m_pend;
   logic [6:0]  m_held;

   bcd_display_scanner #(
      .NUM_DIGITS  (4),
      .REFRESH_DIV (8),
      .BLANK_GAP   (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .load        (load),
      .value_in    (value_in),
      .lz_blank_en (lz_blank_en),
      .seg         (seg),
      .an          (an),
      .digit_idx   (digit_idx),
      .pending     (pending),
      .frame_done  (frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      assert (got === want) passes++;
      else $error("FAIL %s got %0h want %0h", tag, got, want);
   endtask

   function automatic logic [6:0] pattern(input int v);
      case (v)
         0: return 7'b0000001;
         1: return 7'b1001111;
         2: return 7'b0010010;
         3: return 7'b0000110;
         4: return 7'b1001100;
         5: return 7'b0100100;
         6: return 7'b0100000;
         7: return 7'b0001111;
         8: return 7'b0000000;
         9: return 7'b0001100;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [6:0] model_seg(input int d, input logic [15:0] a, input bit lz);
      int upper;
      upper = int'(a) >> (4*d);
      if (lz && d > 0 && upper == 0)
         return 7'b1111111;
      return pattern(upper % 16);
   endfunction

   task automatic model_reset();
      n      = 0;
      m_act  = '0;
      m_sh   = '0;
      m_pend = 0;
      m_held = 7'b1111111;
   endtask

   task automatic check_all(input string t);
      logic [3:0] ea;
      logic [6:0] es;
      int ph, d;
      ph = n % 8;
      d  = (n / 8) % 4;
      ea = 4'b1111;
      es = 7'b1111111;
      if (ph >= 2) begin
         ea = 4'b0001 << d;
         ea = ~ea;
         es = m_held;
      end
      chk({t, ".an"},  32'(an), 32'(ea));
      chk({t, ".seg"}, 32'(seg), 32'(es));
      chk({t, ".idx"}, 32'(digit_idx), 32'(d));
      chk({t, ".pend"}, 32'(pending), 32'(m_pend));
      chk({t, ".fd"}, 32'(frame_done), 32'((n > 0) && (n % 32 == 0)));
   endtask

   task automatic step(input bit l, input logic [15:0] v);
      load     = l;
      value_in = v;
      @(posedge clk);
      n++;
      if (n % 32 == 0) begin
         if (l) m_act = v;
         else if (m_pend) m_act = m_sh;
         m_pend = 0;
         if (l) m_sh = v;
      end else if (l) begin
         m_sh   = v;
         m_pend = 1;
      end
      if (n % 8 == 2)
         m_held = model_seg((n / 8) % 4, m_act, lz_blank_en);
      @(negedge clk);
      load = 1'b0;
      check_all($sformatf("n%0d", n));
   endtask

   task automatic run(input int k);
      for (int i = 0; i < k; i++) step(0, 16'h0);
   endtask

   task automatic to_wrap();
      while ((n + 1) % 32 != 0) step(0, 16'h0);
      step(0, 16'h0);
   endtask

   task automatic show_value(input logic [15:0] v);
      step(1, v);
      to_wrap();
      run(32);
   endtask

   initial begin
      rst         = 1'b1;
      load        = 1'b0;
      value_in    = '0;
      lz_blank_en = 1'b0;
      model_reset();
      @(negedge clk);
      check_all("reset");
      rst = 1'b0;

      // scan timing from reset, then a mid-frame load held back until the wrap
      run(4);
      step(1, 16'h1234);
      to_wrap();
      run(32);

      lz_blank_en = 1'b1;
      show_value(16'h0050);
      show_value(16'h0000);
      lz_blank_en = 1'b0;
      show_value(16'h00A7);

      // load landing exactly on the wrap edge
      while ((n + 1) % 32 != 0) step(0, 16'h0);
      step(1, 16'h9999);
      run(32);

      for (int i = 0; i < 320; i++) begin
         logic [15:0] v;
         bit          l;
         for (int j = 0; j < 4; j++) begin
            v[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         end
         if ($urandom_range(0, 3) == 0) v[15:8] = 8'h00;
         l = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 19) == 0) lz_blank_en = ~lz_blank_en;
         step(l, v);
      end

      // asynchronous reset mid-SHOW of digit 2, with a nonzero value on display
      show_value(16'h8888);
      while (n % 32 != 19) step(0, 16'h0);
      #2 rst = 1'b1;
      #1;
      chk("async.an", 32'(an), 32'hF);
      chk("async.seg", 32'(seg), 32'h7F);
      chk("async.idx", 32'(digit_idx), 32'h0);
      model_reset();
      @(negedge clk);
      check_all("in_reset");
      rst = 1'b0;
      run(2);
      chk("after_rst.seg0", 32'(seg), 32'h01);
      run(40);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running want finished");
      $fatal(1, "timeout");
   end

endmodule
